mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/custom_pkg.sv | 15 +
 rtl/riscv_pkg.sv | 4 +
 rtl/mem_arb_pick.sv | 53 +++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/custom_pkg.sv
// Arbiter FSM state and transaction-owner encodings.
package custom_pkg;
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM,
        OWN_DBG
    } arb_owner_t;
endpackage

// File: rtl/riscv_pkg.sv
// Core-wide architectural constants shared by the memory subsystem.
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection with an IF starvation counter.
// Priority is DM > IF > DBG until IF has been denied StarveLimit times in a row.
module mem_arb_pick
    import custom_pkg::*;
#(
    parameter int StarveLimit = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       i_en,
    input  logic       i_if_req,
    input  logic       i_dm_req,
    input  logic       i_dbg_req,
    output arb_owner_t o_winner
);
    localparam int CntW = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    logic [CntW-1:0] r_starve_cnt;
    logic            w_if_first;

    assign w_if_first = (r_starve_cnt == CntMax);

    always_comb begin
        o_winner = OWN_NONE;
        if (i_en) begin
            if (w_if_first && i_if_req) begin
                o_winner = OWN_IF;
            end else if (i_dm_req) begin
                o_winner = OWN_DM;
            end else if (i_if_req) begin
                o_winner = OWN_IF;
            end else if (i_dbg_req) begin
                o_winner = OWN_DBG;
            end
        end
    end

    // Only arbitration cycles count as denials; the count holds while a transfer is in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve_cnt <= '0;
        end else if (!i_if_req) begin
            r_starve_cnt <= '0;
        end else if (i_en) begin
            if (o_winner == OWN_IF) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != CntMax) begin
                r_starve_cnt <= r_starve_cnt + CntW'(1);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Three-port (IF / DM / debug) single-outstanding memory arbiter.
// Debug port arbitration is enabled by defining MEM_ARBITER_DBG_EN.
module mem_arbiter
    import riscv_pkg::*;
    import custom_pkg::*;
#(
    parameter int StarveLimit = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [3:0]      dm_be_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,

    input  logic            dbg_req_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ready_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    arb_state_t      r_state;
    arb_state_t      w_state_next;
    arb_owner_t      r_owner;
    arb_owner_t      w_winner;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic            w_pick_en;
    logic            w_dbg_req;

`ifdef MEM_ARBITER_DBG_EN
    assign w_dbg_req = dbg_req_i;
`else
    logic w_unused_dbg;
    assign w_unused_dbg = dbg_req_i;
    assign w_dbg_req    = 1'b0;
`endif

    // Gating with rstn_i keeps every grant low while reset is held.
    assign w_pick_en = rstn_i && (r_state == IDLE);

    mem_arb_pick #(
        .StarveLimit (StarveLimit)
    ) u_pick (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .i_en      (w_pick_en),
        .i_if_req  (if_req_i),
        .i_dm_req  (dm_req_i),
        .i_dbg_req (w_dbg_req),
        .o_winner  (w_winner)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Reads always latch be=4'hF and zero wdata so the memory sees clean fields.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= '0;
        end else if (w_pick_en && (w_winner != OWN_NONE)) begin
            r_owner <= w_winner;
            case (w_winner)
                OWN_DM: begin
                    r_addr  <= dm_addr_i;
                    r_we    <= dm_we_i;
                    r_be    <= dm_we_i ? dm_be_i : 4'hF;
                    r_wdata <= dm_we_i ? dm_wdata_i : '0;
                end
                OWN_DBG: begin
                    r_addr  <= dbg_addr_i;
                    r_we    <= 1'b0;
                    r_be    <= 4'hF;
                    r_wdata <= '0;
                end
                default: begin
                    r_addr  <= if_addr_i;
                    r_we    <= 1'b0;
                    r_be    <= 4'hF;
                    r_wdata <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        if_gnt_o     = 1'b0;
        dm_gnt_o     = 1'b0;
        dbg_gnt_o    = 1'b0;
        if_rvalid_o  = 1'b0;
        dm_rvalid_o  = 1'b0;
        dbg_rvalid_o = 1'b0;
        if_rdata_o   = '0;
        dm_rdata_o   = '0;
        dbg_rdata_o  = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'h0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (r_state)
            IDLE: begin
                if_gnt_o = (w_winner == OWN_IF);
                dm_gnt_o = (w_winner == OWN_DM);
`ifdef MEM_ARBITER_DBG_EN
                dbg_gnt_o = (w_winner == OWN_DBG);
`endif
                if (w_winner != OWN_NONE) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_be_o    = r_be;
                mem_addr_o  = r_addr;
                mem_wdata_o = r_wdata;
                if (mem_ready_i) begin
                    w_state_next = r_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    case (r_owner)
                        OWN_IF: begin
                            if_rvalid_o = 1'b1;
                            if_rdata_o  = mem_rdata_i;
                        end
                        OWN_DM: begin
                            dm_rvalid_o = 1'b1;
                            dm_rdata_o  = mem_rdata_i;
                        end
`ifdef MEM_ARBITER_DBG_EN
                        OWN_DBG: begin
                            dbg_rvalid_o = 1'b1;
                            dbg_rdata_o  = mem_rdata_i;
                        end
`endif
                        default: ;
                    endcase
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; debug checks follow MEM_ARBITER_DBG_EN.
module tb_mem_arbiter;
    import riscv_pkg::*;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            if_req_i = 1'b0;
    logic [XLEN-1:0] if_addr_i = '0;
    logic            if_gnt_o, if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [3:0]      dm_be_i = 4'h0;
    logic [XLEN-1:0] dm_addr_i = '0, dm_wdata_i = '0;
    logic            dm_gnt_o, dm_rvalid_o;
    logic [XLEN-1:0] dm_rdata_o;
    logic            dbg_req_i = 1'b0;
    logic [XLEN-1:0] dbg_addr_i = '0;
    logic            dbg_gnt_o, dbg_rvalid_o;
    logic [XLEN-1:0] dbg_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o;
    logic            mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [XLEN-1:0] mem_rdata_i = '0;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.StarveLimit(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_gnt_o(dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives the control inputs for the current cycle and lets combinational outputs settle.
    task automatic applyStimulus(input logic ifReq, input logic dmReq, input logic dmWe,
                                 input logic dbgReq, input logic memReady, input logic memRvalid);
        if_req_i     = ifReq;
        dm_req_i     = dmReq;
        dm_we_i      = dmWe;
        dbg_req_i    = dbgReq;
        mem_ready_i  = memReady;
        mem_rvalid_i = memRvalid;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state, with a request pending that must not be granted
        if_addr_i = 32'h10;
        applyStimulus(1, 1, 0, 0, 1, 1);
        checkOutput("rst_if_gnt", {31'd0, if_gnt_o}, 0);
        checkOutput("rst_dm_gnt", {31'd0, dm_gnt_o}, 0);
        checkOutput("rst_mem_req", {31'd0, mem_req_o}, 0);
        checkOutput("rst_mem_addr", mem_addr_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();

        // IF read at 0x10
        if_addr_i = 32'h10;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("if_gnt", {31'd0, if_gnt_o}, 1);
        checkOutput("if_gnt_dm", {31'd0, dm_gnt_o}, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("if_issue_req", {31'd0, mem_req_o}, 1);
        checkOutput("if_issue_addr", mem_addr_o, 32'h10);
        checkOutput("if_issue_we", {31'd0, mem_we_o}, 0);
        checkOutput("if_issue_be", {28'd0, mem_be_o}, 32'hF);
        checkOutput("if_gnt_once", {31'd0, if_gnt_o}, 0);
        tick();
        mem_rdata_i = 32'hDEADBEEF;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("if_rvalid", {31'd0, if_rvalid_o}, 1);
        checkOutput("if_rdata", if_rdata_o, 32'hDEADBEEF);
        checkOutput("if_rd_dm_rvalid", {31'd0, dm_rvalid_o}, 0);
        checkOutput("if_rd_dm_rdata", dm_rdata_o, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("if_rvalid_pulse", {31'd0, if_rvalid_o}, 0);
        checkOutput("if_rdata_idle", if_rdata_o, 0);

        // Simultaneous IF read and DM write: DM first
        if_addr_i = 32'h20; dm_addr_i = 32'h30; dm_be_i = 4'b0011; dm_wdata_i = 32'h1234;
        applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("both_dm_gnt", {31'd0, dm_gnt_o}, 1);
        checkOutput("both_if_gnt", {31'd0, if_gnt_o}, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("dmw_we", {31'd0, mem_we_o}, 1);
        checkOutput("dmw_be", {28'd0, mem_be_o}, 32'h3);
        checkOutput("dmw_addr", mem_addr_o, 32'h30);
        checkOutput("dmw_wdata", mem_wdata_o, 32'h1234);
        checkOutput("dmw_no_if_gnt", {31'd0, if_gnt_o}, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("dmw_idle_req", {31'd0, mem_req_o}, 0);
        checkOutput("dmw_no_rvalid", {31'd0, dm_rvalid_o}, 0);
        checkOutput("after_if_gnt", {31'd0, if_gnt_o}, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("ifr_addr", mem_addr_o, 32'h20);
        checkOutput("ifr_wdata", mem_wdata_o, 0);
        tick();
        mem_rdata_i = 32'h55;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("ifr_rvalid", {31'd0, if_rvalid_o}, 1);
        tick();

        // Starvation: DM write every arbitration, IF held
        dm_addr_i = 32'h80; dm_be_i = 4'hF; dm_wdata_i = 32'h1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 1, 1, 0, 1, 0);
            checkOutput($sformatf("starve_dm_gnt%0d", k), {31'd0, dm_gnt_o}, (k <= 4) ? 1 : 0);
            checkOutput($sformatf("starve_if_gnt%0d", k), {31'd0, if_gnt_o}, (k == 5) ? 1 : 0);
            tick();
            checkOutput($sformatf("starve_issue%0d", k), {31'd0, mem_req_o}, 1);
            tick();
        end
        mem_rdata_i = 32'hA5;
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("starve_if_rvalid", {31'd0, if_rvalid_o}, 1);
        tick();
        applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("starve_clr_dm", {31'd0, dm_gnt_o}, 1);
        checkOutput("starve_clr_if", {31'd0, if_gnt_o}, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();

        // Memory stall of 3 cycles on a DM read
        dm_addr_i = 32'h44; if_addr_i = 32'h48;
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("stall_dm_gnt", {31'd0, dm_gnt_o}, 1);
        tick();
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput($sformatf("stall_req%0d", s), {31'd0, mem_req_o}, 1);
            checkOutput($sformatf("stall_addr%0d", s), mem_addr_o, 32'h44);
            checkOutput($sformatf("stall_if_gnt%0d", s), {31'd0, if_gnt_o}, 0);
            tick();
        end
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("stall_accept_req", {31'd0, mem_req_o}, 1);
        checkOutput("stall_accept_be", {28'd0, mem_be_o}, 32'hF);
        tick();
        mem_rdata_i = 32'h77;
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("stall_wait_if_gnt", {31'd0, if_gnt_o}, 0);
        checkOutput("stall_dm_rvalid", {31'd0, dm_rvalid_o}, 1);
        checkOutput("stall_dm_rdata", dm_rdata_o, 32'h77);
        checkOutput("stall_if_rvalid", {31'd0, if_rvalid_o}, 0);
        checkOutput("stall_if_rdata", if_rdata_o, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("post_rvalid_if_gnt", {31'd0, if_gnt_o}, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();

        // Reset asserted while waiting for read data
        if_addr_i = 32'h50;
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        rstn_i = 1'b0;
        #1;
        checkOutput("rstw_mem_req", {31'd0, mem_req_o}, 0);
        tick();
        rstn_i = 1'b1;
        mem_rdata_i = 32'hBAD;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rstw_if_rvalid", {31'd0, if_rvalid_o}, 0);
        checkOutput("rstw_dm_rvalid", {31'd0, dm_rvalid_o}, 0);
        checkOutput("rstw_dbg_rvalid", {31'd0, dbg_rvalid_o}, 0);
        checkOutput("rstw_if_rdata", if_rdata_o, 0);
        checkOutput("rstw_mem_addr", mem_addr_o, 0);
        tick();
        dm_addr_i = 32'h60; dm_be_i = 4'b1100; dm_wdata_i = 32'hCAFE0000;
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("rstw_next_gnt", {31'd0, dm_gnt_o}, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("rstw_next_addr", mem_addr_o, 32'h60);
        checkOutput("rstw_next_be", {28'd0, mem_be_o}, 32'hC);
        tick();

        // Debug read at 0x40, contending with IF first
        if_addr_i = 32'h70; dbg_addr_i = 32'h40;
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("dbg_vs_if_if", {31'd0, if_gnt_o}, 1);
        checkOutput("dbg_vs_if_dbg", {31'd0, dbg_gnt_o}, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 0);
        tick();
        mem_rdata_i = 32'h31;
        applyStimulus(0, 0, 0, 1, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0);
`ifdef MEM_ARBITER_DBG_EN
        checkOutput("dbg_gnt", {31'd0, dbg_gnt_o}, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("dbg_addr", mem_addr_o, 32'h40);
        checkOutput("dbg_we", {31'd0, mem_we_o}, 0);
        tick();
        mem_rdata_i = 32'h99;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("dbg_rvalid", {31'd0, dbg_rvalid_o}, 1);
        checkOutput("dbg_rdata", dbg_rdata_o, 32'h99);
        checkOutput("dbg_if_rvalid", {31'd0, if_rvalid_o}, 0);
        tick();
`else
        checkOutput("dbg_off_gnt", {31'd0, dbg_gnt_o}, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("dbg_off_mem_req", {31'd0, mem_req_o}, 0);
        checkOutput("dbg_off_gnt2", {31'd0, dbg_gnt_o}, 0);
        checkOutput("dbg_off_rvalid", {31'd0, dbg_rvalid_o}, 0);
        checkOutput("dbg_off_rdata", dbg_rdata_o, 0);
        tick();
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
